// File: rtl/text_console.sv
// text_console: byte-stream character terminal that acts as a bus master
// on the memory-mapped text RAM and cursor registers of the text display.
//
// Optional feature macro: TEXT_CONSOLE_SCROLL_EN
//   defined   - LF or wrap on the last row scrolls the screen up by one row.
//   undefined - it wraps to row 0 and clears that row instead.
//
// Ports:
//   clk, reset      core clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   byte input handshake
//   busy            FSM is not idle
//   strobe, rw, addr, d_out     bus access (one access per strobe cycle)
//   d_in            read data, valid the cycle after a read strobe
`ifndef VIDEO_ADDR
`define VIDEO_ADDR 32'h0000_8000
`endif

module text_console #(
  parameter logic [31:0] VIDEO_ADDR = `VIDEO_ADDR,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned COLS       = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        strobe,
  output logic        rw,
  output logic [31:0] addr,
  output logic [31:0] d_out,
  input  logic [31:0] d_in
);

  localparam int unsigned AW    = $clog2(ROWS * COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [AW-1:0]    CELL_LAST = AW'(ROWS * COLS - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [AW-1:0]    LAST_ROW_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0]    COPY_LAST     = AW'((ROWS - 1) * COLS - 1);
`endif
  localparam logic [31:0] CRX_ADDR = VIDEO_ADDR + 32'h0000_0FFE;
  localparam logic [31:0] CRY_ADDR = VIDEO_ADDR + 32'h0000_0FFD;

  localparam logic [7:0] CHR_BS    = 8'h08;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUT    = 3'd1,
    CLR    = 3'd2,
    CUR_X  = 3'd3,
    CUR_Y  = 3'd4
`ifdef TEXT_CONSOLE_SCROLL_EN
    ,
    SCR_RD = 3'd5,
    SCR_WR = 3'd6
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    clr_end_q, clr_end_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             rw_q, rw_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       dout_q, dout_d;

  logic             go_cur, go_scroll, go_clr;
  logic [AW-1:0]    clr_start, clr_stop;
  logic [31:0]      cell_addr;

  assign cell_addr = VIDEO_ADDR + 32'(row_q) * 32'(COLS) + 32'(col_q);

  // State, cursor and registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      clr_end_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      clr_end_q  <= clr_end_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
    end
  end

  // Next state; bus outputs are computed for the state being entered so
  // each strobe lines up with the state that owns the access.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    clr_end_d = clr_end_q;
    strobe_d  = 1'b0;
    rw_d      = 1'b1;
    addr_d    = addr_q;
    dout_d    = dout_q;
    go_cur    = 1'b0;
    go_scroll = 1'b0;
    go_clr    = 1'b0;
    clr_start = '0;
    clr_stop  = '0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          case (in_data)
            CHR_CR: begin
              col_d  = '0;
              go_cur = 1'b1;
            end
            CHR_LF: begin
              col_d = '0;
              if (row_q != ROW_LAST) begin
                row_d  = row_q + ROW_W'(1);
                go_cur = 1'b1;
              end else begin
                go_scroll = 1'b1;
              end
            end
            CHR_BS: begin
              if (col_q != '0) col_d = col_q - COL_W'(1);
              go_cur = 1'b1;
            end
            CHR_FF: begin
              row_d     = '0;
              col_d     = '0;
              go_clr    = 1'b1;
              clr_start = '0;
              clr_stop  = CELL_LAST;
            end
            default: begin
              state_d  = PUT;
              strobe_d = 1'b1;
              addr_d   = cell_addr;
              dout_d   = in_data;
            end
          endcase
        end
      end
      // Glyph written this cycle; advance the cursor, wrapping like LF
      PUT: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q != ROW_LAST) begin
            row_d  = row_q + ROW_W'(1);
            go_cur = 1'b1;
          end else begin
            go_scroll = 1'b1;
          end
        end else begin
          col_d  = col_q + COL_W'(1);
          go_cur = 1'b1;
        end
      end
`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD: begin
        state_d  = SCR_WR;
        strobe_d = 1'b1;
        addr_d   = VIDEO_ADDR + 32'(cnt_q);
      end
      SCR_WR: begin
        if (cnt_q == COPY_LAST) begin
          go_clr    = 1'b1;
          clr_start = LAST_ROW_BASE;
          clr_stop  = CELL_LAST;
        end else begin
          cnt_d    = cnt_q + AW'(1);
          state_d  = SCR_RD;
          strobe_d = 1'b1;
          rw_d     = 1'b0;
          addr_d   = VIDEO_ADDR + 32'(cnt_q) + 32'(COLS + 1);
        end
      end
`endif
      CLR: begin
        if (cnt_q == clr_end_q) begin
          go_cur = 1'b1;
        end else begin
          cnt_d    = cnt_q + AW'(1);
          strobe_d = 1'b1;
          addr_d   = VIDEO_ADDR + 32'(cnt_q) + 32'd1;
          dout_d   = CHR_SPACE;
        end
      end
      CUR_X: begin
        state_d  = CUR_Y;
        strobe_d = 1'b1;
        addr_d   = CRY_ADDR;
        dout_d   = 8'(row_q);
      end
      CUR_Y: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_scroll) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      state_d  = SCR_RD;
      cnt_d    = '0;
      strobe_d = 1'b1;
      rw_d     = 1'b0;
      addr_d   = VIDEO_ADDR + 32'(COLS);
`else
      row_d     = '0;
      go_clr    = 1'b1;
      clr_start = '0;
      clr_stop  = AW'(COLS - 1);
`endif
    end

    if (go_clr) begin
      state_d   = CLR;
      cnt_d     = clr_start;
      clr_end_d = clr_stop;
      strobe_d  = 1'b1;
      addr_d    = VIDEO_ADDR + 32'(clr_start);
      dout_d    = CHR_SPACE;
    end

    // crx register is 1-based
    if (go_cur) begin
      state_d  = CUR_X;
      strobe_d = 1'b1;
      addr_d   = CRX_ADDR;
      dout_d   = 8'(col_d) + 8'd1;
    end

    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign strobe   = strobe_q;
  assign rw       = rw_q;
  assign addr     = addr_q;

`ifdef TEXT_CONSOLE_SCROLL_EN
  // Copy data arrives the cycle after the read; forward it into the write
  logic unused_d_in_hi;
  assign unused_d_in_hi = ^d_in[31:8];
  assign d_out = {24'h0, (state_q == SCR_WR) ? d_in[7:0] : dout_q};
`else
  logic unused_d_in;
  assign unused_d_in = ^d_in;
  assign d_out = {24'h0, dout_q};
`endif

endmodule

// File: doc/text_console.md
# text_console

Bus-initiator character terminal that drives the memory-mapped text framebuffer and cursor registers of the VGA text display. Accepts a byte stream over a valid/ready handshake, interprets a small set of control codes, writes glyph codes into the ROWS×COLS text RAM, maintains the cursor, and scrolls the screen by bus read/write copies. Sits on the core clock domain as a bus master alongside, or instead of, the CPU's video writes.

## Interface
Parameters:
- `VIDEO_ADDR`, default `` `VIDEO_ADDR ``: base byte address of the text RAM. Cell (r,c) is at `VIDEO_ADDR + r*COLS + c`.
- `ROWS`, default 32: text rows.
- `COLS`, default 64: text columns.

Ports:
- `clk  in  1`: core clock. One clock; every register is on `clk`.
- `reset  in  1`: asynchronous, active-low reset.
- `in_valid  in  1`: input byte valid.
- `in_data  in  8`: input byte.
- `in_ready  out  1`: block accepts a byte this cycle.
- `busy  out  1`: the FSM is not in IDLE.
- `strobe  out  1`: bus access strobe, one cycle per access.
- `rw  out  1`: 1 = write, 0 = read.
- `addr  out  32`: bus address.
- `d_out  out  32`: write data. Bits [31:8] are always 0.
- `d_in  in  32`: read data. Valid exactly one cycle after a read strobe. Only [7:0] is used.

## Operation
- Cursor registers: `col` (0..COLS-1) and `row` (0..ROWS-1). Both reset to 0.
- Handshake: a byte transfers when `in_valid && in_ready`. `in_ready` = (state == IDLE) and not in reset.
- Byte handling:
  - 0x0D (CR): `col` ← 0.
  - 0x0A (LF): `col` ← 0. If `row` < ROWS-1, `row` ← `row`+1; otherwise scroll.
  - 0x08 (BS): if `col` > 0, `col` ← `col`-1. No erase.
  - 0x0C (FF): write 0x20 to every cell, then `row` ← 0 and `col` ← 0.
  - Any other byte: write it to (`row`,`col`), then advance `col`. At `col` = COLS-1 the cursor wraps to `col` 0 and advances `row` as LF does, including scroll.
- Scroll:
  - For each destination cell d = 0..(ROWS-1)*COLS-1: read `VIDEO_ADDR+d+COLS`, then write the returned byte to `VIDEO_ADDR+d`.
  - Then write 0x20 to all COLS cells of row ROWS-1.
  - `row` stays at ROWS-1.
- Cursor publish: after every accepted byte, two writes are issued.
  - `col+1` to `VIDEO_ADDR+0x1000-2` (crx is 1-based).
  - `row` to `VIDEO_ADDR+0x1000-3` (cry).
- FSM states and transitions:
  - IDLE → PUT (printable), CLR (FF), SCR_RD (LF/wrap at last row), or CUR_X (CR, BS, LF without scroll).
  - PUT → CUR_X, or → SCR_RD on wrap at the last row.
  - SCR_RD → SCR_WR. SCR_WR → SCR_RD, or → CLR (last row) after the final copy.
  - CLR → CLR until its range is done, then → CUR_X.
  - CUR_X → CUR_Y → IDLE.
- Bus outputs:
  - `strobe` is high only in PUT, SCR_RD, SCR_WR, CLR and CUR_X/CUR_Y.
  - `rw` is 0 only in SCR_RD.
  - Address counter width is `$clog2(ROWS*COLS)`.

## Timing
- Reset value of every output: `in_ready`=0 while reset is asserted, 1 on the first `clk` after release. `busy`=0, `strobe`=0, `rw`=0, `addr`=0, `d_out`=0.
- All bus outputs are registered. There are no wait states: every strobe cycle completes one access.
- Printable byte accepted at cycle T:
  - PUT strobe at T+1.
  - CUR_X at T+2, CUR_Y at T+3.
  - `in_ready` high at T+4.
- CR, BS, or LF without scroll: CUR_X at T+1, CUR_Y at T+2, ready at T+3.
- Scroll: 2·(ROWS-1)·COLS copy cycles, plus COLS clear cycles, plus 2 cursor cycles. With defaults: 3968 + 64 + 2.
- FF: ROWS·COLS clear cycles plus 2 cursor cycles.
- `d_in` is sampled on the SCR_WR cycle, i.e. the cycle after the SCR_RD strobe. SCR_WR drives the sampled byte combinationally into the registered write path for that access.
- Reset mid-operation: all state is abandoned immediately and `strobe` drops asynchronously. Partially copied or cleared screen contents are left as-is. The cursor returns to (0,0) with no cursor-register writes.
- `in_valid` while busy: the byte is held off. No byte is lost or duplicated.

## Configuration
- `TEXT_CONSOLE_SCROLL_EN` defined: scroll as described above.
- Undefined: scroll is replaced by wrap-and-clear.
  - `row` ← 0, and row 0 is cleared to 0x20 (COLS writes).
  - SCR_RD and SCR_WR are not built. `rw` is never 0 and `d_in` is unused.

## Test plan
- Reset, then send 'A' (0x41) → write 0x41 @ VIDEO_ADDR. Then write 2 @ VIDEO_ADDR+0xFFE and 0 @ VIDEO_ADDR+0xFFD. `in_ready` returns 4 cycles after acceptance.
- 64 × 'x' then 'y' → 'y' written @ VIDEO_ADDR+64. Cursor writes crx=2, cry=1.
- Preload the RAM model with row r = byte r, set `row`=31, send LF:
  - With the macro: RAM row 0 = 1, …, row 30 = 31, row 31 = 0x20; busy for 4034 cycles.
  - Without the macro: row 0 = 0x20, cry=0.
- Send BS at col 0 → no RAM write, crx=1. Send "ab" then BS → crx=2.
- Send FF → 2048 writes of 0x20, then crx=1 and cry=0. `in_valid` held high throughout: no acceptance until `busy` falls.
- Assert `reset` mid-scroll → `strobe`=0 within the same cycle. After release, 'Z' is written @ VIDEO_ADDR.
